ifid_skid_stage: RTL

//  Parametrised IF/ID pipeline stage carrying instruction, PC, PC+2 and fetch-error bit from fetch to decode.

---
 rtl/ifid_pkg.sv | 33 +++
 rtl/ifid_skid_stage_pipe_payload_reg.sv | 36 +++
 rtl/ifid_skid_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ifid_pkg.sv
// Shared definitions for the IF/ID skid stage: occupancy states, NOP encoding, payload layout.
package ifid_pkg;

   localparam int unsigned IFID_INSTR_W = 16;
   localparam int unsigned IFID_PC_W    = 16;
   localparam int unsigned IFID_CNT_W   = 8;

   // opcode 00001, all other fields zero
   localparam logic [15:0] IFID_NOP_INSTR = 16'h0800;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   typedef struct packed {
      logic [IFID_INSTR_W-1:0] instr;
      logic [IFID_PC_W-1:0]    pc;
      logic [IFID_PC_W-1:0]    pc_plus2;
      logic                    err;
   } payload_t;

   function automatic payload_t nop_payload();
      payload_t p;
      p.instr    = IFID_NOP_INSTR;
      p.pc       = '0;
      p.pc_plus2 = '0;
      p.err      = 1'b0;
      return p;
   endfunction

endpackage

// File: rtl/ifid_skid_stage_pipe_payload_reg.sv
// Payload-wide register with load enable and synchronous clear; clear and reset both return it to RST_VAL.
module pipe_payload_reg #(
   parameter int unsigned   W       = 49,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (clr_i) begin
         data_d = RST_VAL;
      end else if (ld_i) begin
         data_d = d_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= RST_VAL;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage with a 2-entry skid buffer; in_ready depends on occupancy state only.
//  state | meaning
//  EMPTY | nothing held, outputs show NOP/0
//  ONE   | main register holds the output entry
//  TWO   | main and skid both full, input stalled
module ifid_skid_stage
   import ifid_pkg::*;
#(
   parameter int unsigned        INSTR_W   = IFID_INSTR_W,
   parameter int unsigned        PC_W      = IFID_PC_W,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IFID_NOP_INSTR),
   parameter int unsigned        CNT_W     = IFID_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [PC_W-1:0]    in_pc_plus2,
   input  logic               in_err,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [PC_W-1:0]    out_pc_plus2,
   output logic               out_err,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam int unsigned   PW     = INSTR_W + 2*PC_W + 1;
   localparam logic [PW-1:0] NOP_PL = {NOP_INSTR, {(2*PC_W+1){1'b0}}};

   occ_e            state_q, state_d;
   logic            in_fire, out_fire;
   logic            main_ld, skid_ld, main_from_skid;
   logic [PW-1:0]   in_pl, main_d, main_q, skid_q, out_pl;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   assign in_ready  = (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign in_pl     = {in_instr, in_pc, in_pc_plus2, in_err};

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               state_d = ONE;
               main_ld = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_ld = 1'b1;
            end else if (in_fire) begin
               state_d = TWO;
               skid_ld = 1'b1;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               state_d        = ONE;
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      // flush squashes held entries and any same-cycle in_fire
      if (flush) begin
         state_d = EMPTY;
         main_ld = 1'b0;
         skid_ld = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   assign main_d = main_from_skid ? skid_q : in_pl;

   pipe_payload_reg #(.W(PW), .RST_VAL(NOP_PL)) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (flush),
      .ld_i  (main_ld),
      .d_i   (main_d),
      .q_o   (main_q)
   );

   pipe_payload_reg #(.W(PW), .RST_VAL(NOP_PL)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (flush),
      .ld_i  (skid_ld),
      .d_i   (in_pl),
      .q_o   (skid_q)
   );

   // main can hold a stale drained entry while EMPTY, so gate with out_valid
   assign out_pl = out_valid ? main_q : NOP_PL;
   assign {out_instr, out_pc, out_pc_plus2, out_err} = out_pl;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule
